// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding, access length codes and byte count helper.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b11;
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    return len == LEN_B ? 3'd1 : len == LEN_H ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and MEM requests onto one 8-bit RAM, one byte access per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              busy
);
  state_t state;
  logic [2:0] cnt, n;
  logic own_mem;
  logic [ADDR_W-1:0] base;
  logic [31:0] wdata, acc, acc_nx;
  logic [4:0] sh;
  assign busy = state != IDLE;
  // ram_din belongs to the address issued last cycle, i.e. lane cnt-1
  assign sh = {cnt[1:0] - 2'd1, 3'b000};
  assign acc_nx = acc | (32'(ram_din) << sh);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      n <= '0;
      own_mem <= 1'b0;
      base <= '0;
      wdata <= '0;
      acc <= '0;
      ram_addr <= '0;
      ram_we <= 1'b0;
      ram_dout <= '0;
      if_rdata <= '0;
      mem_rdata <= '0;
      if_done <= 1'b0;
      mem_done <= 1'b0;
    end else begin
      if_done <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: if (mem_req || if_req) begin
          own_mem <= mem_req;
          base <= mem_req ? mem_addr : if_addr;
          n <= mem_req ? len_bytes(mem_len) : len_bytes(LEN_W);
          wdata <= mem_wdata;
          acc <= '0;
          cnt <= '0;
          state <= mem_req && mem_we ? WR : RD;
        end
        RD: begin
          if (cnt != 3'd0) acc <= acc_nx;
          if (cnt == n) begin
            state <= DONE;
            if (own_mem) begin
              mem_done <= 1'b1;
              mem_rdata <= acc_nx;
            end else begin
              if_done <= 1'b1;
              if_rdata <= acc_nx;
            end
          end else begin
            ram_addr <= base + ADDR_W'(cnt);
            cnt <= cnt + 3'd1;
          end
        end
        WR: if (cnt == n) begin
          ram_we <= 1'b0;
          mem_done <= 1'b1;
          mem_rdata <= '0;
          state <= DONE;
        end else begin
          ram_addr <= base + ADDR_W'(cnt);
          ram_dout <= wdata[{cnt[1:0], 3'b000} +: 8];
          ram_we <= 1'b1;
          cnt <= cnt + 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller that shares the single 8-bit-wide instruction/data RAM between the fetch stage and the MEM stage. It accepts 32-bit read requests from fetch and 8/16/32-bit read/write requests from MEM, arbitrates between them, and sequences one RAM byte access per cycle. It sits between the pipeline front end (PC/fetch) and the external RAM and replaces the direct PC-to-ROM connection.

## Interface
- ADDR_W, 32, byte-address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  ADDR_W  fetch byte address
- if_rdata  out  32  fetched instruction
- if_done  out  1  one-cycle pulse; if_rdata valid in same cycle
- mem_req  in  1  MEM request, level, held until mem_done
- mem_we  in  1  1 = write, 0 = read
- mem_len  in  2  00 byte, 01 half, 11 word; 10 reserved, treated as word
- mem_addr  in  ADDR_W  MEM byte address
- mem_wdata  in  32  write data, little-endian, low bytes used
- mem_rdata  out  32  read data, zero-extended
- mem_done  out  1  one-cycle pulse; mem_rdata valid in same cycle
- ram_addr  out  ADDR_W  RAM byte address (registered)
- ram_we  out  1  RAM write strobe (registered)
- ram_dout  out  8  RAM write byte (registered)
- ram_din  in  8  RAM read byte, valid one cycle after its address
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: sample requests. mem_req has priority over if_req; simultaneous requests -> MEM served, fetch waits with if_req held. Latch addr, len (fetch always word), we, wdata; cnt <= 0; go RD or WR.
- RD: drive ram_addr = A + cnt for cnt = 0..n-1, ram_we = 0; capture ram_din one cycle later into byte lane cnt-1. After byte n-1 is captured, go DONE.
- WR: drive ram_addr = A + cnt, ram_dout = wdata byte cnt, ram_we = 1 for n consecutive cycles; then go DONE with ram_we = 0.
- DONE: pulse owner's done for exactly one cycle, present assembled data; ignore all requests this cycle; next state IDLE.
- n = 1/2/4 from len. Assembly little-endian: byte k -> bits [8k+7:8k]; unused upper bits zero. Sign extension is MEM stage's job.
- Address arithmetic modulo 2^ADDR_W: A + k wraps to 0. Unaligned addresses legal.
- Write done carries mem_rdata = 0.
- if_rdata / mem_rdata hold value until the owner's next done.
- Requester drops or changes req on the edge after seeing done; the DONE state guarantees that stale req is never re-accepted.

## Timing
- Reset (rst low, async): state IDLE, cnt 0, ram_addr 0, ram_we 0, ram_dout 0, if_rdata 0, mem_rdata 0, if_done 0, mem_done 0, busy 0.
- Reset mid-access: access aborted, no done pulse, no further ram_we.
- Request sampled at edge E0 -> first RAM address at E0+1 -> done high in cycle after edge E0+n+1 (word: 5 cycles, byte: 2 cycles) for both reads and writes.
- Back-to-back: earliest next accept at edge after DONE, i.e. one idle-sample cycle per access; word fetch throughput 1 per 7 cycles.
- busy high from E0 through the DONE cycle.
- Starvation: MEM issues at most one access per instruction, so fetch waits at most one MEM access.

## Structure
- Shared package: state enum (IDLE, RD, WR, DONE), len encodings LEN_B = 2'b00, LEN_H = 2'b01, LEN_W = 2'b11, and a len-to-bytecount function; reused by the MEM stage.
- Single module; no sub-module is natural, since byte-lane assembly is a few lines indexed by cnt.

## Test plan
- Reset then fetch: RAM bytes 0x13,0x05,0x10,0x00 at 0x0 -> if_done 5 cycles after accept, if_rdata = 0x00100513, ram_we never high.
- Simultaneous if_req (0x4) and mem_req byte read (0x8 = 0xFF) -> mem_done first, mem_rdata = 0x000000FF; fetch served next, if_done 7 cycles after mem_done.
- Half write 0xBEEF to 0x11 (unaligned) -> ram_we high 2 cycles, 0xEF @0x11, 0xBE @0x12; word read of 0x10 returns 0x00BEEF00 with RAM 0x10/0x13 pre-zeroed.
- Word read at 0xFFFFFFFE (ADDR_W=32) -> ram_addr sequence FFFFFFFE, FFFFFFFF, 0, 1; bytes assembled in that order.
- rst pulsed low during third byte of a word write -> ram_we 0 immediately, no mem_done, busy 0; subsequent fetch completes normally.
- req held through DONE cycle -> exactly one done pulse per request, no duplicate access.
